// File: rtl/instr_sequencer.sv
// Timestep controller for the 10-bit processor. It fetches into the IR at T0,
// then decodes (T, INSTR) into bus, register-file and ALU strobes.
module instr_sequencer #(
  parameter int DW  = 10,
  parameter int RW  = 2,
  parameter int FNW = 4
) (
  input  logic           CLKb,
  input  logic           CLRn,
  input  logic [DW-1:0]  INSTR,
  output logic [RW-1:0]  Rin,
  output logic [RW-1:0]  Rout,
  output logic           ENW,
  output logic           ENR,
  output logic           Ain,
  output logic           Gin,
  output logic           Gout,
  output logic [FNW-1:0] ALUcont,
  output logic           Ext,
  output logic           IRin,
  output logic [1:0]     T,
  output logic           Clr,
  output logic           ERR
);

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0, OP_MOV, OP_ADD, OP_SUB, OP_INV,
    OP_NEG, OP_AND, OP_OR, OP_XOR, OP_ADDI
  } opcode_e;

  tstep_e          t_q, t_d;
  logic            err_q, err_d;
  opcode_e         op;
  logic [RW-1:0]   rx, ry;
  logic            illegal;
  logic            unused_mid;

  logic [RW-1:0]   rin_c, rout_c;
  logic            enw_c, enr_c, ain_c, gin_c, gout_c, ext_c, irin_c, clr_c;
  logic [FNW-1:0]  alu_c;

  assign op         = opcode_e'(INSTR[3:0]);
  assign rx         = INSTR[DW-1 -: RW];
  assign ry         = INSTR[DW-1-RW -: RW];
  assign illegal    = (INSTR[3:0] > 4'd9);
  assign unused_mid = ^INSTR[DW-2*RW-1:4];

  always_comb begin
    rin_c  = '0;
    rout_c = '0;
    enw_c  = 1'b0;
    enr_c  = 1'b0;
    ain_c  = 1'b0;
    gin_c  = 1'b0;
    gout_c = 1'b0;
    ext_c  = 1'b0;
    irin_c = 1'b0;
    clr_c  = 1'b0;
    unique case (t_q)
      T0: begin
        ext_c  = 1'b1;
        irin_c = 1'b1;
      end
      T1: begin
        case (op)
          OP_LOAD: begin
            ext_c = 1'b1; rin_c = rx; enw_c = 1'b1; clr_c = 1'b1;
          end
          OP_MOV: begin
            rout_c = ry; enr_c = 1'b1; rin_c = rx; enw_c = 1'b1; clr_c = 1'b1;
          end
          OP_INV, OP_NEG: begin
            rout_c = ry; enr_c = 1'b1; gin_c = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
            rout_c = rx; enr_c = 1'b1; ain_c = 1'b1;
          end
          default: clr_c = 1'b1;
        endcase
      end
      T2: begin
        case (op)
          OP_INV, OP_NEG: begin
            gout_c = 1'b1; rin_c = rx; enw_c = 1'b1; clr_c = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            rout_c = ry; enr_c = 1'b1; gin_c = 1'b1;
          end
          OP_ADDI: begin
            ext_c = 1'b1; gin_c = 1'b1;
          end
          default: clr_c = 1'b1;
        endcase
      end
      T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
            gout_c = 1'b1; rin_c = rx; enw_c = 1'b1; clr_c = 1'b1;
          end
          default: clr_c = 1'b1;
        endcase
      end
      default: clr_c = 1'b1;
    endcase
  end

  // ADDI reuses the adder, so its function code is ADD rather than its opcode
  assign alu_c = !gin_c          ? '0 :
                 (op == OP_ADDI) ? FNW'(4'b0010) :
                                   FNW'(INSTR[3:0]);

  assign t_d   = clr_c ? T0 : tstep_e'(t_q + 2'd1);
  assign err_d = err_q | ((t_q == T1) & illegal);

  always_ff @(posedge CLKb) begin
    if (!CLRn) begin
      t_q   <= T0;
      err_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      err_q <= err_d;
    end
  end

  // Strobes are suppressed while reset is held so an aborted write never lands
  assign Rin     = CLRn ? rin_c  : '0;
  assign Rout    = CLRn ? rout_c : '0;
  assign ENW     = CLRn & enw_c;
  assign ENR     = CLRn & enr_c;
  assign Ain     = CLRn & ain_c;
  assign Gin     = CLRn & gin_c;
  assign Gout    = CLRn & gout_c;
  assign ALUcont = CLRn ? alu_c  : '0;
  assign Ext     = CLRn & ext_c;
  assign IRin    = CLRn & irin_c;
  assign Clr     = CLRn & clr_c;
  assign T       = t_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: builds a per-instruction micro-step schedule from the
// instruction set and compares every cycle of the sequencer against it.
module tb_instr_sequencer;

  logic       CLKb, CLRn;
  logic [9:0] INSTR;
  logic [1:0] Rin, Rout, T;
  logic       ENW, ENR, Ain, Gin, Gout, Ext, IRin, Clr, ERR;
  logic [3:0] ALUcont;

  instr_sequencer #(.DW(10), .RW(2), .FNW(4)) dut (
    .CLKb(CLKb), .CLRn(CLRn), .INSTR(INSTR),
    .Rin(Rin), .Rout(Rout), .ENW(ENW), .ENR(ENR), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .ALUcont(ALUcont), .Ext(Ext), .IRin(IRin), .T(T),
    .Clr(Clr), .ERR(ERR)
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  typedef struct packed {
    logic [1:0] t;
    logic       err;
    logic [1:0] rin, rout;
    logic       enw, enr, ain, gin, gout;
    logic [3:0] alu;
    logic       ext, irin, clr;
  } exp_t;

  exp_t q[$];
  logic err_m;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t idle(input logic [1:0] t, input logic err);
    exp_t e;
    e = '0;
    e.t = t;
    e.err = err;
    return e;
  endfunction

  // Micro-step schedule for one instruction: fetch, then the operand/ALU/writeback steps
  task automatic build(input logic [9:0] ins, output exp_t s [0:3], output int n);
    logic [1:0] rx, ry;
    logic [3:0] op;
    rx = ins[9:8];
    ry = ins[7:6];
    op = ins[3:0];
    for (int i = 0; i < 4; i++) s[i] = idle(2'(i), err_m);
    s[0].ext = 1; s[0].irin = 1;
    if (op == 4'd0) begin
      n = 2;
      s[1].ext = 1; s[1].rin = rx; s[1].enw = 1; s[1].clr = 1;
    end else if (op == 4'd1) begin
      n = 2;
      s[1].rout = ry; s[1].enr = 1; s[1].rin = rx; s[1].enw = 1; s[1].clr = 1;
    end else if (op == 4'd4 || op == 4'd5) begin
      n = 3;
      s[1].rout = ry; s[1].enr = 1; s[1].gin = 1; s[1].alu = op;
      s[2].gout = 1; s[2].rin = rx; s[2].enw = 1; s[2].clr = 1;
    end else if (op <= 4'd9) begin
      n = 4;
      s[1].rout = rx; s[1].enr = 1; s[1].ain = 1;
      if (op == 4'd9) begin
        s[2].ext = 1; s[2].gin = 1; s[2].alu = 4'd2;
      end else begin
        s[2].rout = ry; s[2].enr = 1; s[2].gin = 1; s[2].alu = op;
      end
      s[3].gout = 1; s[3].rin = rx; s[3].enw = 1; s[3].clr = 1;
    end else begin
      n = 2;
      s[1].clr = 1;
    end
  endtask

  task automatic reset_cycles(input int n);
    CLRn = 1'b0;
    err_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      q.push_back(idle(2'd0, 1'b0));
      @(posedge CLKb); #1;
    end
    CLRn = 1'b1;
  endtask

  // abort >= instruction length means run to completion; otherwise reset lands in step 'abort'
  task automatic run(input logic [9:0] ins, input int abort);
    exp_t s [0:3];
    int n;
    INSTR = ins;
    build(ins, s, n);
    for (int i = 0; i < n; i++) begin
      if (i == abort) begin
        q.push_back(idle(2'(i), err_m));
        CLRn = 1'b0;
        @(posedge CLKb); #1;
        reset_cycles(1);
        return;
      end
      q.push_back(s[i]);
      @(posedge CLKb); #1;
    end
    if (ins[3:0] > 4'd9) err_m = 1'b1;
  endtask

  always @(negedge CLKb) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("strobes", 32'({Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont, Ext, IRin, Clr}),
          32'({e.rin, e.rout, e.enw, e.enr, e.ain, e.gin, e.gout, e.alu, e.ext, e.irin, e.clr}));
      chk("T", 32'(T), 32'(e.t));
      chk("ERR", 32'(ERR), 32'(e.err));
      chk("single_bus_driver", 32'(int'(Ext) + int'(ENR) + int'(Gout) <= 1), 32'd1);
      chk("no_ENW_in_T0", 32'(ENW && T == 2'd0), 32'd0);
    end
  end

  initial begin
    exp_t s [0:3];
    int n;
    err_m = 1'b0;
    CLRn  = 1'b0;
    INSTR = '0;
    @(posedge CLKb); #1;
    reset_cycles(2);

    build(10'b10_00_00_0000, s, n);
    chk("pin_load_len", 32'(n), 32'd2);
    chk("pin_load_t1", 32'({s[1].ext, s[1].rin, s[1].enw, s[1].clr, s[1].enr, s[1].gout}), 32'b1_10_1_1_0_0);
    build(10'b01_11_00_0010, s, n);
    chk("pin_add_len", 32'(n), 32'd4);
    chk("pin_add_t1", 32'({s[1].rout, s[1].ain}), 32'b01_1);
    chk("pin_add_t2", 32'({s[2].rout, s[2].gin, s[2].alu}), 32'b11_1_0010);
    chk("pin_add_t3", 32'({s[3].gout, s[3].rin, s[3].enw, s[3].clr}), 32'b1_01_1_1);
    build(10'b00_10_00_0101, s, n);
    chk("pin_neg_len", 32'(n), 32'd3);
    chk("pin_neg_alu", 32'({s[1].alu, s[2].alu}), 32'h50);
    chk("pin_neg_t2", 32'({s[2].gout, s[2].rin, s[2].enw, s[2].clr}), 32'b1_00_1_1);
    build(10'b11_00_00_1001, s, n);
    chk("pin_addi_t2", 32'({s[2].ext, s[2].enr, s[2].gin, s[2].alu}), 32'b1_0_1_0010);
    build(10'b01_10_00_1100, s, n);
    chk("pin_illegal", 32'({n[1:0], s[1].clr, s[1].enw, s[1].ext, s[1].enr, s[1].gout}), 32'b10_1_0_0_0_0);

    run(10'b10_00_00_0000, 4);   // LOAD R2
    run(10'b01_11_00_0010, 4);   // ADD R1,R3
    run(10'b00_10_00_0101, 4);   // NEG R0,R2
    run(10'b01_10_00_1100, 4);   // illegal 1100
    run(10'b00_01_00_0001, 4);   // MOV with ERR still set
    run(10'b11_00_00_1001, 4);   // ADDI R3
    run(10'b10_01_00_0100, 4);   // INV
    run(10'b11_11_00_1111, 4);   // illegal 1111
    run(10'b10_01_00_0011, 2);   // SUB aborted at T2
    run(10'b01_00_00_1000, 4);   // XOR after reset, ERR cleared

    for (int k = 0; k < 200; k++) begin
      logic [9:0] ins;
      ins = 10'($urandom);
      if (k % 40 == 39) run(ins, int'($urandom_range(0, 3)));
      else run(ins, 4);
    end

    @(negedge CLKb);
    chk("schedule_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-timestep control FSM for the 10-bit processor. It fetches an instruction from the external switch input into the instruction register. It then sequences the register file, the ALU (A and G registers) and the external-input bus driver over T0..T3, with at most one bus driver enabled per cycle. It replaces the separate controller/upcount2 pair and exports the timestep, done and error status for the output display logic.

Parameters:
DW, 10, data/instruction width
RW, 2, register address width (4 registers)
FNW, 4, ALU function code width

Ports:
CLKb  input  1  debounced step clock; all state updates on rising edge
CLRn  input  1  reset; synchronous, active-low
INSTR  input  DW  IR contents; valid from T1 onward
Rin  output  RW  register file write address (WRA)
Rout  output  RW  register file read address (RDA0)
ENW  output  1  register file write enable
ENR  output  1  register file read port 0 bus drive enable
Ain  output  1  ALU A-register load
Gin  output  1  ALU G-register load
Gout  output  1  ALU G bus drive enable
ALUcont  output  FNW  ALU function code (FN)
Ext  output  1  external switch input bus drive enable
IRin  output  1  instruction register load
T  output  2  current timestep, for THEX
Clr  output  1  last timestep of instruction; drives DONE
ERR  output  1  sticky illegal-opcode flag

Behaviour:
- Instruction fields: INSTR[9:8]=Rx (destination), INSTR[7:6]=Ry (source), INSTR[5:4] ignored, INSTR[3:0]=opcode.
- Opcodes:
  - 0000 LOAD: Rx<-D.
  - 0001 MOV: Rx<-Ry.
  - 0010 ADD: Rx<-Rx+Ry.
  - 0011 SUB: Rx<-Rx-Ry.
  - 0100 INV: Rx<-~Ry.
  - 0101 NEG: Rx<--Ry.
  - 0110 AND.
  - 0111 OR.
  - 1000 XOR.
  - 1001 ADDI: Rx<-Rx+D.
  - 1010..1111: illegal.
- ALUcont equals the opcode whenever Gin=1; otherwise 0000. ADDI drives ALUcont=0010.
- State is a 2-bit timestep register T. All strobes are combinational decode of (T, INSTR), Moore style. Each strobe is a single cycle. Outputs not listed for a step are 0.
- T0 (every instruction): Ext=1, IRin=1. Next: T1.
- LOAD, T1: Ext=1, Rin=Rx, ENW=1, Clr=1. Next: T0.
- MOV, T1: Rout=Ry, ENR=1, Rin=Rx, ENW=1, Clr=1. Next: T0.
- INV/NEG:
  - T1: Rout=Ry, ENR=1, Gin=1.
  - T2: Gout=1, Rin=Rx, ENW=1, Clr=1. Next: T0.
- ADD/SUB/AND/OR/XOR:
  - T1: Rout=Rx, ENR=1, Ain=1.
  - T2: Rout=Ry, ENR=1, Gin=1.
  - T3: Gout=1, Rin=Rx, ENW=1, Clr=1. Next: T0.
- ADDI:
  - T1: Rout=Rx, ENR=1, Ain=1.
  - T2: Ext=1, Gin=1.
  - T3: Gout=1, Rin=Rx, ENW=1, Clr=1. Next: T0.
- Illegal opcode, T1: Clr=1, ENW=0, no bus driver enabled. ERR is set on that edge. Next: T0.
- Instruction lengths: LOAD/MOV 2 cycles; INV/NEG 3 cycles; binary ops and ADDI 4 cycles.
- Invariant: at most one of {Ext, ENR, Gout} is 1 in any cycle.
- Invariant: ENW is never 1 in T0.
- Clr=1 exactly one cycle per instruction. T always returns to 0 after a Clr cycle, never wraps 3->0 without Clr.
- An unreachable T/opcode combination (e.g. T3 with MOV) produces Clr=1 with all other strobes 0, then returns to T0.
- Reset: CLRn=0 sampled on a CLKb edge sets T=0 and ERR=0.
  - While CLRn=0, all strobes (Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont, Ext, IRin, Clr) are forced to 0.
  - After release, the first cycle is T0 with Ext=IRin=1.
- Reset mid-instruction aborts it. No ENW is issued in the reset cycle.
- INSTR changing outside T0 does not occur by construction (IRin only in T0). The FSM samples INSTR combinationally each cycle.

Test Plan:
- Reset: CLRn=0 for 2 edges, then release -> T=0, ERR=0, all strobes 0 while low; first cycle after release has Ext=1, IRin=1.
- LOAD R2, INSTR=10_00_00_0000 -> T sequence 0,1,0; at T1: Ext=1, Rin=2, ENW=1, Clr=1; ENR=Gout=0.
- ADD R1,R3, INSTR=01_11_00_0010 -> T sequence 0,1,2,3,0:
  - T1: Rout=1, Ain=1.
  - T2: Rout=3, Gin=1, ALUcont=0010.
  - T3: Gout=1, Rin=1, ENW=1, Clr=1.
- NEG R0,R2, INSTR=00_10_00_0101 -> 3-cycle sequence; T2 has Gout=1, Rin=0, ENW=1, Clr=1; ALUcont=0101 only at T1.
- Illegal opcode 1100 -> T1: Clr=1, ENW=0, no bus driver; ERR=1 and stays 1 through a following legal MOV; cleared only by CLRn=0.
- Reset asserted at T2 of a SUB -> no ENW issued; after release T=0; every cycle of a randomized 200-instruction run satisfies the single-bus-driver invariant.
